// File: rtl/mem_read_arbiter_if.sv
// Port bundle for mem_read_arbiter: the data-stage and fetch request channels
// plus the system read bus. The arbiter takes the slave view, its environment the master view.
interface mem_read_arbiter_if #(
    parameter int ADDR_WIDTH  = 64,
    parameter int DATA_WIDTH  = 64,
    parameter int BUFFER_SIZE = 512
);
    logic                   d_req_valid;
    logic [ADDR_WIDTH-1:0]  d_req_addr;
    logic                   d_req_ready;
    logic                   d_resp_valid;
    logic [BUFFER_SIZE-1:0] d_resp_data;

    logic                   i_req_valid;
    logic [ADDR_WIDTH-1:0]  i_req_addr;
    logic                   i_req_ready;
    logic                   i_resp_valid;
    logic [BUFFER_SIZE-1:0] i_resp_data;

    logic [ADDR_WIDTH-1:0]  S_R_ADDR;
    logic                   S_R_ADDR_VALID;
    logic                   S_R_ADDR_READY;
    logic [DATA_WIDTH-1:0]  S_R_DATA;
    logic                   S_R_DATA_VALID;

    modport slave (
        input  d_req_valid, d_req_addr,
        input  i_req_valid, i_req_addr,
        input  S_R_ADDR_READY, S_R_DATA, S_R_DATA_VALID,
        output d_req_ready, d_resp_valid, d_resp_data,
        output i_req_ready, i_resp_valid, i_resp_data,
        output S_R_ADDR, S_R_ADDR_VALID
    );

    modport master (
        output d_req_valid, d_req_addr,
        output i_req_valid, i_req_addr,
        output S_R_ADDR_READY, S_R_DATA, S_R_DATA_VALID,
        input  d_req_ready, d_resp_valid, d_resp_data,
        input  i_req_ready, i_resp_valid, i_resp_data,
        input  S_R_ADDR, S_R_ADDR_VALID
    );
endinterface

// File: rtl/mem_read_arbiter.sv
// Shares one memory read port between the data stage (D) and instruction fetch (I):
// one line fill at a time, round-robin on ties, BEATS beats assembled into one line.
//
// state | meaning
// IDLE  | no transaction; arbitrate D/I requests
// ADDR  | present line-aligned address until S_R_ADDR_READY
// DATA  | collect BEATS beats into the line buffer
// RESP  | hand the line to the owner with a one-cycle resp_valid
module mem_read_arbiter #(
    parameter int ADDR_WIDTH  = 64,
    parameter int DATA_WIDTH  = 64,
    parameter int BEATS       = 8,
    parameter int BUFFER_SIZE = DATA_WIDTH * BEATS
) (
    input  logic              clk,
    input  logic              reset,
    mem_read_arbiter_if.slave bus,
    output logic              busy
);
    localparam int CTR_W  = $clog2(BEATS);
    localparam int OFFS_W = $clog2(BUFFER_SIZE / 8);
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
        ~((ADDR_WIDTH'(1) << OFFS_W) - ADDR_WIDTH'(1));
    localparam logic [CTR_W-1:0] LAST_BEAT = CTR_W'(BEATS - 1);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;
    typedef enum logic {OWN_D, OWN_I} owner_t;

    state_t                 r_state,        w_state_nxt;
    owner_t                 r_owner,        w_owner_nxt;
    logic [CTR_W-1:0]       r_beat_ctr,     w_beat_ctr_nxt;
    logic [BUFFER_SIZE-1:0] r_line,         w_line_nxt;
    logic [ADDR_WIDTH-1:0]  r_addr,         w_addr_nxt;
    logic                   r_addr_valid,   w_addr_valid_nxt;
    logic                   r_d_req_ready,  w_d_req_ready_nxt;
    logic                   r_i_req_ready,  w_i_req_ready_nxt;
    logic                   r_d_resp_valid, w_d_resp_valid_nxt;
    logic                   r_i_resp_valid, w_i_resp_valid_nxt;
    logic [BUFFER_SIZE-1:0] r_d_resp_data,  w_d_resp_data_nxt;
    logic [BUFFER_SIZE-1:0] r_i_resp_data,  w_i_resp_data_nxt;
    logic                   r_busy,         w_busy_nxt;
    logic                   w_grant_d;
    logic                   w_grant_i;

    // r_owner doubles as last_owner: it keeps the previous winner once the fill is done
    assign w_grant_d = bus.d_req_valid && (!bus.i_req_valid || (r_owner == OWN_I));
    assign w_grant_i = bus.i_req_valid && !w_grant_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= IDLE;
            r_owner        <= OWN_I;
            r_beat_ctr     <= '0;
            r_line         <= '0;
            r_addr         <= '0;
            r_addr_valid   <= 1'b0;
            r_d_req_ready  <= 1'b0;
            r_i_req_ready  <= 1'b0;
            r_d_resp_valid <= 1'b0;
            r_i_resp_valid <= 1'b0;
            r_d_resp_data  <= '0;
            r_i_resp_data  <= '0;
            r_busy         <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_owner        <= w_owner_nxt;
            r_beat_ctr     <= w_beat_ctr_nxt;
            r_line         <= w_line_nxt;
            r_addr         <= w_addr_nxt;
            r_addr_valid   <= w_addr_valid_nxt;
            r_d_req_ready  <= w_d_req_ready_nxt;
            r_i_req_ready  <= w_i_req_ready_nxt;
            r_d_resp_valid <= w_d_resp_valid_nxt;
            r_i_resp_valid <= w_i_resp_valid_nxt;
            r_d_resp_data  <= w_d_resp_data_nxt;
            r_i_resp_data  <= w_i_resp_data_nxt;
            r_busy         <= w_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt        = r_state;
        w_owner_nxt        = r_owner;
        w_beat_ctr_nxt     = r_beat_ctr;
        w_line_nxt         = r_line;
        w_addr_nxt         = r_addr;
        w_addr_valid_nxt   = r_addr_valid;
        w_d_req_ready_nxt  = 1'b0;
        w_i_req_ready_nxt  = 1'b0;
        w_d_resp_valid_nxt = 1'b0;
        w_i_resp_valid_nxt = 1'b0;
        w_d_resp_data_nxt  = r_d_resp_data;
        w_i_resp_data_nxt  = r_i_resp_data;

        case (r_state)
            IDLE: begin
                if (w_grant_d) begin
                    w_d_req_ready_nxt = 1'b1;
                    w_owner_nxt       = OWN_D;
                    w_addr_nxt        = bus.d_req_addr & LINE_MASK;
                    w_state_nxt       = ADDR;
                end else if (w_grant_i) begin
                    w_i_req_ready_nxt = 1'b1;
                    w_owner_nxt       = OWN_I;
                    w_addr_nxt        = bus.i_req_addr & LINE_MASK;
                    w_state_nxt       = ADDR;
                end
            end
            ADDR: begin
                // first ADDR cycle raises valid; READY only counts once valid is visible
                if (!r_addr_valid) begin
                    w_addr_valid_nxt = 1'b1;
                end else if (bus.S_R_ADDR_READY) begin
                    w_addr_valid_nxt = 1'b0;
                    w_beat_ctr_nxt   = '0;
                    w_state_nxt      = DATA;
                end
            end
            DATA: begin
                if (bus.S_R_DATA_VALID) begin
                    w_line_nxt[int'(r_beat_ctr) * DATA_WIDTH +: DATA_WIDTH] = bus.S_R_DATA;
                    if (r_beat_ctr == LAST_BEAT) begin
                        w_state_nxt = RESP;
                    end else begin
                        w_beat_ctr_nxt = r_beat_ctr + CTR_W'(1);
                    end
                end
            end
            RESP: begin
                if (r_owner == OWN_D) begin
                    w_d_resp_valid_nxt = 1'b1;
                    w_d_resp_data_nxt  = r_line;
                end else begin
                    w_i_resp_valid_nxt = 1'b1;
                    w_i_resp_data_nxt  = r_line;
                end
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase

        w_busy_nxt = (w_state_nxt != IDLE);
    end

    assign bus.d_req_ready    = r_d_req_ready;
    assign bus.d_resp_valid   = r_d_resp_valid;
    assign bus.d_resp_data    = r_d_resp_data;
    assign bus.i_req_ready    = r_i_req_ready;
    assign bus.i_resp_valid   = r_i_resp_valid;
    assign bus.i_resp_data    = r_i_resp_data;
    assign bus.S_R_ADDR       = r_addr;
    assign bus.S_R_ADDR_VALID = r_addr_valid;
    assign busy               = r_busy;

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Self-checking bench for mem_read_arbiter: scoreboard queues of expected grants,
// addresses and lines, filled at request time and drained as the DUT responds.
module tb_mem_read_arbiter;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam int NB = 8;
    localparam int BS = DW * NB;
    localparam logic [AW-1:0] ALIGN = 64'hFFFF_FFFF_FFFF_FFC0;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic busy;

    always #5 clk = ~clk;

    mem_read_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BUFFER_SIZE(BS)) bus ();

    mem_read_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BEATS(NB), .BUFFER_SIZE(BS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave),
        .busy  (busy)
    );

    int n_cmp = 0;
    int n_bad = 0;
    longint cyc = 0;
    int cnt_d_ready = 0, cnt_i_ready = 0, cnt_d_resp = 0, cnt_i_resp = 0;

    logic [AW-1:0] exp_addr_q[$];
    logic [BS-1:0] exp_d_q[$];
    logic [BS-1:0] exp_i_q[$];
    bit            exp_own_q[$];
    logic [AW-1:0] d_pend_addr, i_pend_addr;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.d_req_ready === 1'b1)  cnt_d_ready <= cnt_d_ready + 1;
        if (bus.i_req_ready === 1'b1)  cnt_i_ready <= cnt_i_ready + 1;
        if (bus.d_resp_valid === 1'b1) cnt_d_resp  <= cnt_d_resp + 1;
        if (bus.i_resp_valid === 1'b1) cnt_i_resp  <= cnt_i_resp + 1;
    end

    function automatic logic [BS-1:0] make_line(input logic [DW-1:0] base);
        logic [BS-1:0] l;
        l = '0;
        for (int k = 0; k < NB; k++) l[k*DW +: DW] = base + DW'(k);
        return l;
    endfunction

    task automatic issue(input bit is_d, input logic [AW-1:0] addr, input logic [DW-1:0] base,
                         input bit expect_line);
        if (is_d) begin
            bus.d_req_valid = 1'b1;
            bus.d_req_addr  = addr;
            d_pend_addr     = addr & ALIGN;
            if (expect_line) exp_d_q.push_back(make_line(base));
        end else begin
            bus.i_req_valid = 1'b1;
            bus.i_req_addr  = addr;
            i_pend_addr     = addr & ALIGN;
            if (expect_line) exp_i_q.push_back(make_line(base));
        end
    endtask

    task automatic wait_grant(output bit got_d, output longint t);
        int  n;
        bit  exp_d;
        n = 0;
        got_d = 1'b0;
        t = -1;
        while (bus.d_req_ready !== 1'b1 && bus.i_req_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (bus.d_req_ready !== 1'b1 && bus.i_req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL grant_timeout got ready d=%b i=%b want one of them 1", bus.d_req_ready, bus.i_req_ready);
            return;
        end
        got_d = (bus.d_req_ready === 1'b1);
        t = cyc;
        exp_d = (exp_own_q.size() > 0) ? exp_own_q.pop_front() : 1'b0;
        n_cmp++;
        if ({bus.d_req_ready, bus.i_req_ready} !== (exp_d ? 2'b10 : 2'b01)) begin
            n_bad++;
            $display("FAIL grant_owner got d/i ready=%b%b want %b", bus.d_req_ready, bus.i_req_ready,
                     exp_d ? 2'b10 : 2'b01);
        end
        if (got_d) begin
            bus.d_req_valid = 1'b0;
            exp_addr_q.push_back(d_pend_addr);
        end else begin
            bus.i_req_valid = 1'b0;
            exp_addr_q.push_back(i_pend_addr);
        end
    endtask

    task automatic serve_bus(input int ready_delay, input int gap, input int n_beats,
                             input logic [DW-1:0] base, input bit junk_in_addr);
        int n;
        logic [AW-1:0] ea;
        n = 0;
        while (bus.S_R_ADDR_VALID !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (bus.S_R_ADDR_VALID !== 1'b1) begin
            n_bad++;
            $display("FAIL addr_valid_timeout got=%b want=1", bus.S_R_ADDR_VALID);
            return;
        end
        ea = (exp_addr_q.size() > 0) ? exp_addr_q.pop_front() : '1;
        n_cmp++;
        if (bus.S_R_ADDR !== ea) begin
            n_bad++;
            $display("FAIL s_r_addr got=%h want=%h", bus.S_R_ADDR, ea);
        end
        for (int k = 0; k < ready_delay; k++) begin
            if (junk_in_addr) begin
                bus.S_R_DATA_VALID = 1'b1;
                bus.S_R_DATA       = 64'hDEAD_BEEF_0000_0000 | DW'(k);
            end
            @(negedge clk);
            n_cmp++;
            if (bus.S_R_ADDR_VALID !== 1'b1 || bus.S_R_ADDR !== ea) begin
                n_bad++;
                $display("FAIL addr_hold got valid=%b addr=%h want valid=1 addr=%h",
                         bus.S_R_ADDR_VALID, bus.S_R_ADDR, ea);
            end
        end
        bus.S_R_ADDR_READY = 1'b1;
        @(negedge clk);
        bus.S_R_ADDR_READY = 1'b0;
        bus.S_R_DATA_VALID = 1'b0;
        n_cmp++;
        if (bus.S_R_ADDR_VALID !== 1'b0) begin
            n_bad++;
            $display("FAIL addr_valid_drop got=%b want=0", bus.S_R_ADDR_VALID);
        end
        for (int k = 0; k < n_beats; k++) begin
            bus.S_R_DATA       = base + DW'(k);
            bus.S_R_DATA_VALID = 1'b1;
            @(negedge clk);
            if (gap > 0 && k < n_beats - 1) begin
                bus.S_R_DATA_VALID = 1'b0;
                bus.S_R_DATA       = 64'hBAD0_BAD0_BAD0_BAD0;
                repeat (gap) @(negedge clk);
            end
        end
        bus.S_R_DATA_VALID = 1'b0;
    endtask

    task automatic collect_resp(input bit is_d, output longint t);
        int n;
        logic [BS-1:0] el;
        n = 0;
        t = -1;
        while ((is_d ? bus.d_resp_valid : bus.i_resp_valid) !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if ((is_d ? bus.d_resp_valid : bus.i_resp_valid) !== 1'b1) begin
            n_bad++;
            $display("FAIL resp_timeout port_d=%0d got valid=0 want 1", is_d);
            return;
        end
        t = cyc;
        if (is_d) el = (exp_d_q.size() > 0) ? exp_d_q.pop_front() : '1;
        else      el = (exp_i_q.size() > 0) ? exp_i_q.pop_front() : '1;
        n_cmp++;
        if ((is_d ? bus.d_resp_data : bus.i_resp_data) !== el) begin
            n_bad++;
            $display("FAIL resp_data port_d=%0d got=%h want=%h", is_d,
                     is_d ? bus.d_resp_data : bus.i_resp_data, el);
        end
        n_cmp++;
        if ((is_d ? bus.i_resp_valid : bus.d_resp_valid) !== 1'b0) begin
            n_bad++;
            $display("FAIL resp_other_port port_d=%0d got other valid=1 want 0", is_d);
        end
        @(negedge clk);
        n_cmp++;
        if ((is_d ? bus.d_resp_valid : bus.i_resp_valid) !== 1'b0) begin
            n_bad++;
            $display("FAIL resp_pulse_width port_d=%0d got valid=1 want 0", is_d);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.d_req_valid = 1'b0;
        bus.i_req_valid = 1'b0;
        bus.S_R_ADDR_READY = 1'b0;
        bus.S_R_DATA_VALID = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({busy, bus.d_req_ready, bus.i_req_ready, bus.d_resp_valid, bus.i_resp_valid,
             bus.S_R_ADDR_VALID} !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl got=%b want=000000", {busy, bus.d_req_ready, bus.i_req_ready,
                     bus.d_resp_valid, bus.i_resp_valid, bus.S_R_ADDR_VALID});
        end
        n_cmp++;
        if (bus.S_R_ADDR !== '0) begin
            n_bad++;
            $display("FAIL reset_addr got=%h want=0", bus.S_R_ADDR);
        end
        n_cmp++;
        if (bus.d_resp_data !== '0 || bus.i_resp_data !== '0) begin
            n_bad++;
            $display("FAIL reset_resp_data got d=%h i=%h want 0", bus.d_resp_data, bus.i_resp_data);
        end
        reset = 1'b0;
    endtask

    task automatic test_single_d();
        bit got_d;
        longint tg, tr;
        int i_resp0, d_rdy0;
        i_resp0 = cnt_i_resp;
        d_rdy0  = cnt_d_ready;
        issue(1'b1, 64'h1234, 64'h0, 1'b1);
        exp_own_q.push_back(1'b1);
        wait_grant(got_d, tg);
        @(negedge clk);
        n_cmp++;
        if (bus.S_R_ADDR_VALID !== 1'b1 || bus.S_R_ADDR !== 64'h1200) begin
            n_bad++;
            $display("FAIL single_addr_t1 got valid=%b addr=%h want valid=1 addr=1200",
                     bus.S_R_ADDR_VALID, bus.S_R_ADDR);
        end
        serve_bus(0, 0, NB, 64'h0, 1'b0);
        collect_resp(1'b1, tr);
        n_cmp++;
        if (tr - tg != NB + 3) begin
            n_bad++;
            $display("FAIL single_latency got=%0d want=%0d", tr - tg, NB + 3);
        end
        n_cmp++;
        if (cnt_i_resp != i_resp0 || cnt_d_ready != d_rdy0 + 1) begin
            n_bad++;
            $display("FAIL single_pulses got i_resp=%0d d_ready=%0d want 0 and 1",
                     cnt_i_resp - i_resp0, cnt_d_ready - d_rdy0);
        end
    endtask

    task automatic test_round_robin();
        bit got_d;
        longint tg, tr;
        do_reset();
        // after reset the first tie goes to D, then pending I
        issue(1'b1, 64'h8040, 64'h100, 1'b1);
        issue(1'b0, 64'h4000, 64'h200, 1'b1);
        exp_own_q.push_back(1'b1);
        exp_own_q.push_back(1'b0);
        for (int r = 0; r < 2; r++) begin
            wait_grant(got_d, tg);
            serve_bus(0, 0, NB, got_d ? 64'h100 : 64'h200, 1'b0);
            collect_resp(got_d, tr);
        end
        issue(1'b1, 64'h8080, 64'h300, 1'b1);
        issue(1'b0, 64'h40C0, 64'h400, 1'b1);
        exp_own_q.push_back(1'b1);
        exp_own_q.push_back(1'b0);
        for (int r = 0; r < 2; r++) begin
            wait_grant(got_d, tg);
            serve_bus(0, 0, NB, got_d ? 64'h300 : 64'h400, 1'b0);
            collect_resp(got_d, tr);
        end
        // last owner D: a tie now favours I
        issue(1'b1, 64'h0, 64'h500, 1'b1);
        exp_own_q.push_back(1'b1);
        wait_grant(got_d, tg);
        serve_bus(0, 0, NB, 64'h500, 1'b0);
        collect_resp(1'b1, tr);
        issue(1'b1, 64'h9000, 64'h600, 1'b1);
        issue(1'b0, 64'hA000, 64'h700, 1'b1);
        exp_own_q.push_back(1'b0);
        exp_own_q.push_back(1'b1);
        for (int r = 0; r < 2; r++) begin
            wait_grant(got_d, tg);
            serve_bus(0, 0, NB, got_d ? 64'h600 : 64'h700, 1'b0);
            collect_resp(got_d, tr);
        end
    endtask

    task automatic test_addr_stall();
        bit got_d;
        longint tg, tr;
        issue(1'b0, 64'h7FC8, 64'h1000, 1'b1);
        exp_own_q.push_back(1'b0);
        wait_grant(got_d, tg);
        serve_bus(5, 0, NB, 64'h1000, 1'b1);
        collect_resp(1'b0, tr);
    endtask

    task automatic test_gaps();
        bit got_d;
        longint tg, tr;
        bus.S_R_DATA       = 64'hFFFF_0000_FFFF_0000;
        bus.S_R_DATA_VALID = 1'b1;
        repeat (2) @(negedge clk);
        bus.S_R_DATA_VALID = 1'b0;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_spurious_busy got=%b want=0", busy);
        end
        issue(1'b1, 64'h2A10, 64'h2000, 1'b1);
        exp_own_q.push_back(1'b1);
        wait_grant(got_d, tg);
        serve_bus(0, 2, NB, 64'h2000, 1'b0);
        collect_resp(1'b1, tr);
    endtask

    task automatic test_reset_mid();
        bit got_d;
        longint tg, tr;
        int d0, i0;
        issue(1'b1, 64'h3000, 64'h3000, 1'b0);
        exp_own_q.push_back(1'b1);
        wait_grant(got_d, tg);
        serve_bus(0, 0, 3, 64'h3000, 1'b0);
        d0 = cnt_d_resp;
        i0 = cnt_i_resp;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_cmp++;
        if ({busy, bus.d_req_ready, bus.i_req_ready, bus.d_resp_valid, bus.i_resp_valid,
             bus.S_R_ADDR_VALID} !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_mid_ctrl got=%b want=000000", {busy, bus.d_req_ready, bus.i_req_ready,
                     bus.d_resp_valid, bus.i_resp_valid, bus.S_R_ADDR_VALID});
        end
        n_cmp++;
        if (bus.d_resp_data !== '0 || bus.i_resp_data !== '0) begin
            n_bad++;
            $display("FAIL reset_mid_resp_data got d=%h i=%h want 0", bus.d_resp_data, bus.i_resp_data);
        end
        for (int k = 3; k < NB; k++) begin
            bus.S_R_DATA       = 64'h3000 + DW'(k);
            bus.S_R_DATA_VALID = 1'b1;
            @(negedge clk);
        end
        bus.S_R_DATA_VALID = 1'b0;
        repeat (12) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || cnt_d_resp != d0 || cnt_i_resp != i0) begin
            n_bad++;
            $display("FAIL reset_mid_late_beats got busy=%b d_resp=%0d i_resp=%0d want 0 0 0",
                     busy, cnt_d_resp - d0, cnt_i_resp - i0);
        end
        issue(1'b0, 64'h5008, 64'h5000, 1'b1);
        exp_own_q.push_back(1'b0);
        wait_grant(got_d, tg);
        serve_bus(0, 0, NB, 64'h5000, 1'b0);
        collect_resp(1'b0, tr);
    endtask

    task automatic test_i_during_d();
        bit got_d;
        longint tg, td, ti, tr;
        issue(1'b1, 64'h1010, 64'h6000, 1'b1);
        exp_own_q.push_back(1'b1);
        wait_grant(got_d, tg);
        fork
            serve_bus(0, 0, NB, 64'h6000, 1'b0);
            begin
                repeat (4) @(negedge clk);
                issue(1'b0, 64'h2000, 64'h7000, 1'b1);
                exp_own_q.push_back(1'b0);
            end
        join
        collect_resp(1'b1, td);
        wait_grant(got_d, ti);
        n_cmp++;
        if (ti - td != 1) begin
            n_bad++;
            $display("FAIL i_wait_grant_gap got=%0d want=1", ti - td);
        end
        serve_bus(0, 0, NB, 64'h7000, 1'b0);
        collect_resp(1'b0, tr);
        n_cmp++;
        if (bus.d_resp_data !== make_line(64'h6000)) begin
            n_bad++;
            $display("FAIL d_resp_data_kept got=%h want=%h", bus.d_resp_data, make_line(64'h6000));
        end
    endtask

    initial begin
        bus.d_req_valid    = 1'b0;
        bus.d_req_addr     = '0;
        bus.i_req_valid    = 1'b0;
        bus.i_req_addr     = '0;
        bus.S_R_ADDR_READY = 1'b0;
        bus.S_R_DATA       = '0;
        bus.S_R_DATA_VALID = 1'b0;
        test_reset();
        test_single_d();
        test_round_robin();
        test_addr_stall();
        test_gaps();
        test_reset_mid();
        test_i_during_d();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got cycles=%0d want completion before limit", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_read_arbiter.md
Name: mem_read_arbiter

Overview:
- Shares the single memory read port between the data-memory stage (port D) and instruction fetch (port I).
- Accepts one line-fill request at a time and issues the line-aligned address downstream.
- Collects BEATS data beats into one BUFFER_SIZE line and returns the line to the requester that owns the transaction.
- Sits between the pipeline stages and the system read bus.

Parameters:
ADDR_WIDTH, 64, address width
DATA_WIDTH, 64, width of one bus beat
BEATS, 8, beats per line fill (power of 2, at least 2)
BUFFER_SIZE, DATA_WIDTH*BEATS (512), line width returned to requesters

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
d_req_valid  in  1  data-stage read request; held high until accepted
d_req_addr  in  ADDR_WIDTH  data-stage byte address
d_req_ready  out  1  one-cycle pulse when the D request is accepted
d_resp_valid  out  1  one-cycle pulse when the D line is complete
d_resp_data  out  BUFFER_SIZE  D line data
i_req_valid  in  1  fetch read request; held high until accepted
i_req_addr  in  ADDR_WIDTH  fetch byte address
i_req_ready  out  1  one-cycle pulse when the I request is accepted
i_resp_valid  out  1  one-cycle pulse when the I line is complete
i_resp_data  out  BUFFER_SIZE  I line data
S_R_ADDR  out  ADDR_WIDTH  line-aligned read address
S_R_ADDR_VALID  out  1  address valid
S_R_ADDR_READY  in  1  downstream accepts the address
S_R_DATA  in  DATA_WIDTH  read beat
S_R_DATA_VALID  in  1  beat valid
busy  out  1  high in every state other than IDLE

Behaviour:
- States: IDLE, ADDR, DATA, RESP.
- All outputs are registered.
- Reset values: state=IDLE, beat_ctr=0, last_owner=I, all valid/ready/busy outputs 0, S_R_ADDR=0, d_resp_data=0, i_resp_data=0.

IDLE arbitration:
- Only d_req_valid high: grant D. Only i_req_valid high: grant I.
- Both high: grant the port that is not last_owner (round-robin). After reset the first tie goes to D.
- On grant:
  - pulse the granted x_req_ready for one cycle (cycle T);
  - latch owner and address;
  - S_R_ADDR <= address with its low log2(BUFFER_SIZE/8) bits cleared (6 bits at default);
  - last_owner <= owner;
  - go to ADDR.

ADDR:
- S_R_ADDR_VALID=1 from cycle T+1. S_R_ADDR and S_R_ADDR_VALID stay stable until S_R_ADDR_READY is sampled high.
- Then S_R_ADDR_VALID <= 0, beat_ctr <= 0, go to DATA.

DATA:
- Each cycle with S_R_DATA_VALID=1 writes beat k to line bits [k*DATA_WIDTH +: DATA_WIDTH] (beat 0 is least significant), then beat_ctr++.
- Gaps in valid are allowed.
- On beat BEATS-1, go to RESP.
- The assembled line is written to the owner's x_resp_data register only.

RESP:
- Owner's x_resp_valid=1 for exactly one cycle, then IDLE.
- x_resp_data holds its value until that port's next fill completes.
- Latency: at minimum 1 idle cycle is lost after RESP before the next grant. With ADDR_READY immediate and back-to-back beats, resp_valid arrives BEATS+3 cycles after req_ready.

Boundary cases:
- S_R_DATA_VALID in IDLE, ADDR or RESP: ignored, counter unchanged.
- Requests arriving in non-IDLE states: not accepted, and ready stays 0. They wait, and the requester must keep valid asserted.
- A request dropped before acceptance is simply not served; there is no error.
- Request to the same port as the in-flight one: served after RESP.
- The other port's resp_data is never disturbed.
- beat_ctr width is log2(BEATS). It never wraps inside a transaction because the transition to RESP occurs at BEATS-1.
- Reset mid-transaction (ADDR or DATA): return to IDLE with reset values next cycle. The partial line is discarded, no resp_valid is produced, and late beats arriving after reset are ignored.
- Reset also clears both resp_data registers.

Test Plan:
- Single D read, d_req_addr=0x1234, ADDR_READY immediate, beats 0x0..0x7 back-to-back:
  - d_req_ready pulses at T;
  - S_R_ADDR=0x1200 with VALID at T+1;
  - d_resp_valid at T+11;
  - d_resp_data = {64'h7,...,64'h0};
  - i_resp_valid never asserts.
- Simultaneous D and I requests after reset (I addr 0x4000, D addr 0x8040):
  - D is granted first (S_R_ADDR=0x8040), then I (0x4000);
  - a second simultaneous pair serves D again only after I, so grants alternate D, I, D, I.
- ADDR_READY held low 5 cycles:
  - S_R_ADDR_VALID stays 1 with a stable address for 5 cycles;
  - no beats are accepted;
  - normal completion follows.
- Beats with gaps (S_R_DATA_VALID 1,0,0,1,...) plus a spurious S_R_DATA_VALID in IDLE:
  - the line contains only the 8 valid beats in order;
  - the spurious beat has no effect.
- Reset asserted after 3 of 8 beats:
  - next cycle busy=0 and all valid outputs 0;
  - the remaining 5 beats are ignored and no resp_valid is produced;
  - a fresh I request then completes correctly.
- I request arriving while D is in DATA:
  - i_req_ready stays 0 until the cycle after D's RESP;
  - d_resp_data is unchanged by the I fill.
